// File: rtl/asc_control.sv
// rtl/asc_control.sv - control FSM for the line-drawer Avalon-MM slave
// Decodes register writes, launches draws, drives status/waitrequest, and aborts stuck draws.
module asc_control #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_read,
  input  logic       i_write,
  input  logic [2:0] i_address,
  output logic       o_waitrequest,
  input  logic       i_mode,
  output logic       o_status,
  output logic       o_ld_mode,
  output logic       o_ld_sp,
  output logic       o_ld_ep,
  output logic       o_ld_col,
  output logic       o_start,
  input  logic       i_done,
  output logic       o_abort
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, START, BUSY, FINISH} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          go;
  logic          timeout;
  logic          rd_only;

  assign rd_only = i_read & ~i_write;
  assign go      = (state == IDLE) && i_write && (i_address == 3'd2);
  // done has priority over the watchdog in the same cycle
  assign timeout = WD_EN && (state == BUSY) && !i_done && (cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // saturating watchdog counter, cleared on every launch
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == START) begin
      cnt <= '0;
    end else if ((state == BUSY) && !i_done && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = START;
      START:   state_next = BUSY;
      BUSY:    if (i_done || timeout) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_waitrequest = 1'b0;
    o_status      = 1'b0;
    o_ld_mode     = 1'b0;
    o_ld_sp       = 1'b0;
    o_ld_ep       = 1'b0;
    o_ld_col      = 1'b0;
    o_start       = 1'b0;
    o_abort       = 1'b0;
    if (!reset) begin
      // stall mode holds writes from the go accept until FINISH
      o_waitrequest = !i_mode && !rd_only && i_write &&
                      (go || (state == START) || (state == BUSY));
      o_status      = (state == START) || (state == BUSY);
      o_start       = (state == START);
      o_abort       = timeout;
      if ((state == IDLE) && i_write && !o_waitrequest) begin
        o_ld_mode = (i_address == 3'd0);
        o_ld_sp   = (i_address == 3'd3);
        o_ld_ep   = (i_address == 3'd4);
        o_ld_col  = (i_address == 3'd5);
      end
    end
  end

endmodule

// File: tb/tb_asc_control.sv
// tb/tb_asc_control.sv - scoreboard bench for asc_control
// Two instances share stimulus: watchdog disabled (sel 0) and TIMEOUT_CYCLES=8 (sel 1).
module tb_asc_control;

  localparam logic [7:0] W = 8'h80, S = 8'h40, M = 8'h20, P = 8'h10;
  localparam logic [7:0] E = 8'h08, C = 8'h04, G = 8'h02, A = 8'h01;

  logic       clk = 1'b0;
  logic       reset, i_read, i_write, i_mode, i_done;
  logic [2:0] i_address;
  logic       wr0, st0, lm0, ls0, le0, lc0, go0, ab0;
  logic       wr8, st8, lm8, ls8, le8, lc8, go8, ab8;
  logic [7:0] out0, out8;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic       sel_q[$];
  string      tag_q[$];

  logic [7:0] mon_exp;
  logic       mon_sel;
  string      mon_tag;

  always #5 clk = ~clk;

  asc_control #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .i_read(i_read), .i_write(i_write), .i_address(i_address),
    .o_waitrequest(wr0), .i_mode(i_mode), .o_status(st0), .o_ld_mode(lm0), .o_ld_sp(ls0),
    .o_ld_ep(le0), .o_ld_col(lc0), .o_start(go0), .i_done(i_done), .o_abort(ab0)
  );

  asc_control #(.TIMEOUT_CYCLES(8)) dut8 (
    .clk(clk), .reset(reset), .i_read(i_read), .i_write(i_write), .i_address(i_address),
    .o_waitrequest(wr8), .i_mode(i_mode), .o_status(st8), .o_ld_mode(lm8), .o_ld_sp(ls8),
    .o_ld_ep(le8), .o_ld_col(lc8), .o_start(go8), .i_done(i_done), .o_abort(ab8)
  );

  assign out0 = {wr0, st0, lm0, ls0, le0, lc0, go0, ab0};
  assign out8 = {wr8, st8, lm8, ls8, le8, lc8, go8, ab8};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // one clock cycle of stimulus plus the outputs expected during that cycle
  task automatic step(input string tag, input logic sel, input logic rst, input logic rd,
                      input logic wr, input logic [2:0] addr, input logic mode,
                      input logic done, input logic [7:0] exp);
    @(posedge clk);
    #1;
    reset     = rst;
    i_read    = rd;
    i_write   = wr;
    i_address = addr;
    i_mode    = mode;
    i_done    = done;
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_sel = sel_q.pop_front();
      mon_tag = tag_q.pop_front();
      check(mon_tag, mon_sel ? out8 : out0, mon_exp);
    end
  end

  initial begin
    reset = 1'b1; i_read = 1'b0; i_write = 1'b0; i_address = 3'd0;
    i_mode = 1'b0; i_done = 1'b0;

    // reset with a go write presented: nothing may launch
    step("rst_d0", 0, 1, 0, 1, 3'd2, 0, 0, 8'h00);
    step("rst_d8", 1, 1, 0, 1, 3'd2, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step("post_rst", i[0], 0, 0, 0, 3'd0, 0, 0, 8'h00);

    // poll mode configuration and go
    step("ld_mode_p", 0, 0, 0, 1, 3'd0, 0, 0, M);
    step("ld_sp", 0, 0, 0, 1, 3'd3, 1, 0, P);
    step("ld_ep", 0, 0, 0, 1, 3'd4, 1, 0, E);
    step("ld_col", 0, 0, 0, 1, 3'd5, 1, 0, C);
    step("wr_status", 0, 0, 0, 1, 3'd1, 1, 0, 8'h00);
    step("wr_unused", 0, 0, 0, 1, 3'd7, 1, 0, 8'h00);
    step("go_p", 0, 0, 0, 1, 3'd2, 1, 0, 8'h00);
    step("start_p", 0, 0, 0, 0, 3'd0, 1, 0, S | G);
    for (int i = 0; i < 3; i++) step("busy_p", 0, 0, 0, 0, 3'd0, 1, 0, S);
    step("done_p", 0, 0, 0, 0, 3'd0, 1, 1, S);
    step("fin_p_nold", 0, 0, 0, 1, 3'd3, 1, 0, 8'h00);
    step("idle_p_ld", 0, 0, 0, 1, 3'd3, 1, 0, P);
    step("rst", 0, 1, 0, 0, 3'd0, 1, 0, 8'h00);

    // stall mode: go write held through the whole draw
    step("ld_mode_s", 0, 0, 0, 1, 3'd0, 1, 0, M);
    step("go_s", 0, 0, 0, 1, 3'd2, 0, 0, W);
    step("start_s", 0, 0, 0, 1, 3'd2, 0, 0, W | S | G);
    for (int i = 0; i < 8; i++) step("busy_s", 0, 0, 0, 1, 3'd2, 0, 0, W | S);
    step("done_s", 0, 0, 0, 1, 3'd2, 0, 1, W | S);
    step("fin_s", 0, 0, 0, 1, 3'd2, 0, 0, 8'h00);
    step("no_relaunch_s", 0, 0, 0, 0, 3'd0, 0, 0, 8'h00);
    step("idle_s", 0, 0, 0, 0, 3'd0, 0, 0, 8'h00);
    step("idle_rd_s", 0, 0, 1, 0, 3'd1, 0, 0, 8'h00);
    step("rst", 0, 1, 0, 0, 3'd0, 0, 0, 8'h00);

    // poll mode: writes during a draw are dropped, reads never wait
    step("ld_mode_b", 0, 0, 0, 1, 3'd0, 0, 0, M);
    step("go_b", 0, 0, 0, 1, 3'd2, 1, 0, 8'h00);
    step("start_b", 0, 0, 0, 0, 3'd0, 1, 0, S | G);
    step("bsy_sp_drop", 0, 0, 0, 1, 3'd3, 1, 0, S);
    step("bsy_go_drop", 0, 0, 0, 1, 3'd2, 1, 0, S);
    step("bsy_rd_stat", 0, 0, 1, 0, 3'd1, 1, 0, S);
    step("bsy_rw_mode", 0, 0, 1, 1, 3'd0, 1, 0, S);
    step("done_b", 0, 0, 0, 0, 3'd0, 1, 1, S);
    step("fin_b", 0, 0, 0, 0, 3'd0, 1, 0, 8'h00);
    step("idle_b", 0, 0, 0, 0, 3'd0, 1, 0, 8'h00);
    step("rst", 1, 1, 0, 0, 3'd0, 0, 0, 8'h00);

    // watchdog fires on the 8th BUSY cycle, stall mode
    step("wd_go", 1, 0, 0, 1, 3'd2, 0, 0, W);
    step("wd_start", 1, 0, 0, 1, 3'd2, 0, 0, W | S | G);
    for (int i = 0; i < 7; i++) step("wd_busy", 1, 0, 0, 1, 3'd2, 0, 0, W | S);
    step("wd_abort", 1, 0, 0, 1, 3'd2, 0, 0, W | S | A);
    step("wd_fin", 1, 0, 0, 1, 3'd2, 0, 0, 8'h00);
    step("wd_idle", 1, 0, 0, 0, 3'd0, 0, 0, 8'h00);
    step("wd_idle2", 1, 0, 0, 0, 3'd0, 0, 0, 8'h00);
    step("rst", 1, 1, 0, 0, 3'd0, 0, 0, 8'h00);

    // done on the timeout cycle wins
    step("wdd_go", 1, 0, 0, 1, 3'd2, 0, 0, W);
    step("wdd_start", 1, 0, 0, 1, 3'd2, 0, 0, W | S | G);
    for (int i = 0; i < 7; i++) step("wdd_busy", 1, 0, 0, 1, 3'd2, 0, 0, W | S);
    step("wdd_done", 1, 0, 0, 1, 3'd2, 0, 1, W | S);
    step("wdd_fin", 1, 0, 0, 1, 3'd2, 0, 0, 8'h00);
    step("wdd_idle", 1, 0, 0, 0, 3'd0, 0, 0, 8'h00);
    step("rst", 1, 1, 0, 0, 3'd0, 1, 0, 8'h00);

    // reset on what would be the abort cycle, then a clean relaunch
    step("mr_go", 1, 0, 0, 1, 3'd2, 1, 0, 8'h00);
    step("mr_start", 1, 0, 0, 0, 3'd0, 1, 0, S | G);
    for (int i = 0; i < 7; i++) step("mr_busy", 1, 0, 0, 0, 3'd0, 1, 0, S);
    step("mr_reset", 1, 1, 0, 0, 3'd0, 1, 0, 8'h00);
    step("mr_after", 1, 0, 0, 0, 3'd0, 1, 0, 8'h00);
    step("mr_idle_d0", 0, 0, 0, 0, 3'd0, 1, 0, 8'h00);
    step("mr_go2", 1, 0, 0, 1, 3'd2, 1, 0, 8'h00);
    step("mr_start2", 1, 0, 0, 0, 3'd0, 1, 0, S | G);
    step("mr_done2", 1, 0, 0, 0, 3'd0, 1, 1, S);
    step("mr_fin2", 1, 0, 0, 0, 3'd0, 1, 0, 8'h00);
    step("done_ignored", 1, 0, 0, 0, 3'd0, 1, 1, 8'h00);
    step("idle_end", 1, 0, 0, 0, 3'd0, 1, 0, 8'h00);

    repeat (3) @(posedge clk);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
